// File: rtl/rv32_multicycle_lsu_if.sv
// Memory-map bus between the load/store unit and memory.
// Shared types:
//   mem_access_t         : access width (byte/half/word)
//   mem_exception_mask_t : nonzero when memory flags an error on a beat
// Modports:
//   master : LSU side. Drives req/addr/wr_data/wr_ena/access.
//            Receives ready/rd_data/exception.
//   slave  : memory side, mirror of master.
package rv32_lsu_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef logic [3:0] mem_exception_mask_t;
endpackage

interface rv32_multicycle_lsu_if;
    import rv32_lsu_pkg::*;

    logic                mem_req;
    logic                mem_ready;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wr_data;
    logic                mem_wr_ena;
    mem_access_t         mem_access;
    logic [31:0]         mem_rd_data;
    mem_exception_mask_t mem_exception;

    modport master (
        output mem_req, mem_addr, mem_wr_data, mem_wr_ena, mem_access,
        input  mem_ready, mem_rd_data, mem_exception
    );

    modport slave (
        input  mem_req, mem_addr, mem_wr_data, mem_wr_ena, mem_access,
        output mem_ready, mem_rd_data, mem_exception
    );
endinterface

// File: rtl/rv32_multicycle_lsu.sv
// Multicycle load/store unit for the rv32i core.
// It runs the memory phase of LB/LH/LW/LBU/LHU/SB/SH/SW. It provides wait
// states, sign/zero extension and optional byte-splitting of misaligned
// accesses. It reports timeout, memory-exception and illegal-funct3 errors.
//
// Ports:
//   clk, rst              clock; async active-low reset
//   ena                   gates acceptance of new requests only
//   req_*                 core request (valid/ready handshake)
//   resp_*                one-cycle response pulse with data and flags
//   mem (master modport)  memory-map bus
//
// States:
//   S_IDLE   | waiting for a request, req_ready = ena
//   S_ACCESS | single aligned access in progress
//   S_SPLIT  | misaligned access issued as byte beats, idx = current byte
//   S_RESP   | resp_valid pulse, then back to S_IDLE
module rv32_multicycle_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1,
    parameter int MAX_WAIT         = 15,
    parameter int WAIT_W           = $clog2(MAX_WAIT + 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        resp_fault,
    rv32_multicycle_lsu_if.master mem
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, wdata_q, asm_q;
    logic [2:0]          f3_q;
    logic                store_q;
    logic [1:0]          idx_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                misal_q, illegal_q, fault_q;

    logic req_illegal, req_misal, accept, in_beat, beat_err, timeout, last_byte;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'b0, d[7:0]};
            3'b101:  extend = {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = req_store;
            default:                req_illegal = 1'b1;
        endcase
        req_misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    end

    assign accept    = (state_q == S_IDLE) && req_valid && ena;
    assign in_beat   = (state_q == S_ACCESS) || (state_q == S_SPLIT);
    assign beat_err  = mem.mem_ready && (mem.mem_exception != '0);
    // Timeout fires on the cycle the wait count would reach MAX_WAIT, so
    // mem_req is high for exactly MAX_WAIT cycles on a dead bus.
    assign timeout   = (MAX_WAIT != 0) && !mem.mem_ready &&
                       (wait_q == WAIT_W'(MAX_WAIT - 1));
    assign last_byte = (idx_q == (f3_q[1] ? 2'd3 : 2'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'b0;
        resp_misaligned = 1'b0;
        resp_illegal    = 1'b0;
        resp_fault      = 1'b0;
        mem.mem_req     = 1'b0;
        mem.mem_addr    = 32'b0;
        mem.mem_wr_data = 32'b0;
        mem.mem_wr_ena  = 1'b0;
        mem.mem_access  = MEM_ACCESS_BYTE;
        case (state_q)
            S_IDLE: begin
                req_ready = ena;
                if (accept) begin
                    if (req_illegal || (req_misal && ALLOW_MISALIGNED == 0)) state_d = S_RESP;
                    else if (req_misal)                                     state_d = S_SPLIT;
                    else                                                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem.mem_req     = 1'b1;
                mem.mem_addr    = addr_q;
                mem.mem_wr_data = wdata_q;
                mem.mem_wr_ena  = store_q;
                mem.mem_access  = mem_access_t'(f3_q[1:0]);
                if (mem.mem_ready || timeout) state_d = S_RESP;
            end
            S_SPLIT: begin
                mem.mem_req     = 1'b1;
                mem.mem_addr    = addr_q + {30'b0, idx_q};
                mem.mem_wr_data = {24'b0, wdata_q[{idx_q, 3'b000} +: 8]};
                mem.mem_wr_ena  = store_q;
                mem.mem_access  = MEM_ACCESS_BYTE;
                if ((mem.mem_ready && (beat_err || last_byte)) || timeout) state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid      = 1'b1;
                resp_misaligned = misal_q;
                resp_illegal    = illegal_q;
                resp_fault      = fault_q;
                if (!store_q && !misal_q && !illegal_q && !fault_q)
                    resp_rdata = extend(f3_q, asm_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= 32'b0;
            wdata_q   <= 32'b0;
            asm_q     <= 32'b0;
            f3_q      <= 3'b0;
            store_q   <= 1'b0;
            idx_q     <= 2'b0;
            wait_q    <= '0;
            misal_q   <= 1'b0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                f3_q      <= req_funct3;
                store_q   <= req_store;
                asm_q     <= 32'b0;
                idx_q     <= 2'b0;
                wait_q    <= '0;
                illegal_q <= req_illegal;
                misal_q   <= !req_illegal && req_misal && (ALLOW_MISALIGNED == 0);
                fault_q   <= 1'b0;
            end
            if (in_beat) begin
                if (mem.mem_ready) begin
                    wait_q <= '0;
                    if (beat_err) begin
                        fault_q <= 1'b1;
                    end else if (state_q == S_SPLIT) begin
                        asm_q[{idx_q, 3'b000} +: 8] <= mem.mem_rd_data[7:0];
                        idx_q <= idx_q + 2'd1;
                    end else begin
                        asm_q <= mem.mem_rd_data;
                    end
                end else if (timeout) begin
                    fault_q <= 1'b1;
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_lsu.sv
// Directed bench for rv32_multicycle_lsu.
// dut0 runs with ALLOW_MISALIGNED=1 and a byte-array memory model.
// dut1 runs with ALLOW_MISALIGNED=0 on an always-ready bus.
module tb_rv32_multicycle_lsu;
    import rv32_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b1;
    logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic        req_ready0, req_ready1, resp_valid0, resp_valid1;
    logic [31:0] resp_rdata0, resp_rdata1;
    logic        resp_mis0, resp_ill0, resp_flt0, resp_mis1, resp_ill1, resp_flt1;

    rv32_multicycle_lsu_if m0();
    rv32_multicycle_lsu_if m1();

    rv32_multicycle_lsu #(.ALLOW_MISALIGNED(1), .MAX_WAIT(15)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_misaligned(resp_mis0),
        .resp_illegal(resp_ill0), .resp_fault(resp_flt0), .mem(m0));

    rv32_multicycle_lsu #(.ALLOW_MISALIGNED(0), .MAX_WAIT(15)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_misaligned(resp_mis1),
        .resp_illegal(resp_ill1), .resp_fault(resp_flt1), .mem(m1));

    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    int          wait_cfg = 0;
    logic        never_ready = 1'b0;
    int          exc_beat = -1;
    int          beats_base = 0;
    int          wcnt = 0, req_total = 0, req1_total = 0, beats_total = 0, wr_total = 0;
    logic [7:0]  mem_bytes [256];
    logic [31:0] wlog_addr [64];
    logic [31:0] wlog_data [64];

    assign m0.mem_ready     = m0.mem_req && !never_ready && (wcnt == wait_cfg);
    assign m0.mem_exception = (m0.mem_ready && exc_beat >= 0 && (beats_total - beats_base) == exc_beat)
                              ? 4'h2 : 4'h0;
    assign m1.mem_ready     = m1.mem_req;
    assign m1.mem_rd_data   = 32'h0;
    assign m1.mem_exception = 4'h0;

    // Reads are right-justified with junk above the access size,
    // which the LSU must ignore.
    always_comb begin
        logic [7:0] a;
        a = m0.mem_addr[7:0];
        m0.mem_rd_data = 32'h0;
        case (m0.mem_access)
            MEM_ACCESS_BYTE: m0.mem_rd_data = {24'hA5A5A5, mem_bytes[a]};
            MEM_ACCESS_HALF: m0.mem_rd_data = {16'hA5A5, mem_bytes[8'(a + 8'd1)], mem_bytes[a]};
            default:         m0.mem_rd_data = {mem_bytes[8'(a + 8'd3)], mem_bytes[8'(a + 8'd2)],
                                               mem_bytes[8'(a + 8'd1)], mem_bytes[a]};
        endcase
    end

    always @(posedge clk) begin
        if (m0.mem_req && !m0.mem_ready) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
        if (m0.mem_req) req_total <= req_total + 1;
        if (m1.mem_req) req1_total <= req1_total + 1;
        if (m0.mem_req && m0.mem_ready) begin
            beats_total <= beats_total + 1;
            if (m0.mem_wr_ena && m0.mem_exception == 4'h0) begin
                wlog_addr[wr_total % 64] <= m0.mem_addr;
                wlog_data[wr_total % 64] <= m0.mem_wr_data;
                wr_total <= wr_total + 1;
                mem_bytes[m0.mem_addr[7:0]] <= m0.mem_wr_data[7:0];
                if (m0.mem_access != MEM_ACCESS_BYTE)
                    mem_bytes[8'(m0.mem_addr[7:0] + 8'd1)] <= m0.mem_wr_data[15:8];
                if (m0.mem_access == MEM_ACCESS_WORD) begin
                    mem_bytes[8'(m0.mem_addr[7:0] + 8'd2)] <= m0.mem_wr_data[23:16];
                    mem_bytes[8'(m0.mem_addr[7:0] + 8'd3)] <= m0.mem_wr_data[31:24];
                end
            end
        end
    end

    // ---------------- helpers ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int which, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        check("req_ready_before_accept", which == 0 ? req_ready0 : req_ready1, 1);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (which == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
    endtask

    // cyc = cycle of resp_valid counted from the accept edge; 0 means no response.
    task automatic wait_resp(input int which, output int cyc, output logic first_req,
                             output logic [1:0] first_acc, output logic [31:0] rdata,
                             output logic [2:0] flags);
        cyc = 0; first_req = 1'b0; first_acc = 2'b0; rdata = 32'b0; flags = 3'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) begin
                first_req = (which == 0) ? m0.mem_req : m1.mem_req;
                first_acc = m0.mem_access;
            end
            if ((which == 0) ? resp_valid0 : resp_valid1) begin
                cyc = i;
                rdata = (which == 0) ? resp_rdata0 : resp_rdata1;
                flags = (which == 0) ? {resp_mis0, resp_ill0, resp_flt0}
                                     : {resp_mis1, resp_ill1, resp_flt1};
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    int          cyc, r0, w0, b0;
    logic        freq;
    logic [1:0]  facc;
    logic [31:0] rd;
    logic [2:0]  fl;
    logic        seen;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", m0.mem_req, 0);
        check("rst_resp_valid", resp_valid0, 0);
        check("rst_resp_rdata", resp_rdata0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready0", req_ready0, 1);
        check("rst_req_ready1", req_ready1, 1);

        // 1: SW then LW, zero wait
        issue(0, 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("sw_cyc", cyc, 2); check("sw_rdata", rd, 0); check("sw_flags", fl, 0);
        issue(0, 1'b0, 3'b010, 32'h1000_0004, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("lw_req_c1", freq, 1); check("lw_access", facc, MEM_ACCESS_WORD);
        check("lw_cyc", cyc, 2); check("lw_rdata", rd, 32'hDEAD_BEEF);

        // 2: byte/half extension
        issue(0, 1'b1, 3'b000, 32'h1000_0003, 32'h0000_0080);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("sb_cyc", cyc, 2);
        issue(0, 1'b0, 3'b000, 32'h1000_0003, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("lb_access", facc, MEM_ACCESS_BYTE); check("lb_rdata", rd, 32'hFFFF_FF80);
        issue(0, 1'b0, 3'b100, 32'h1000_0003, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("lbu_rdata", rd, 32'h0000_0080);
        issue(0, 1'b1, 3'b001, 32'h1000_0008, 32'h0000_8001);
        wait_resp(0, cyc, freq, facc, rd, fl);
        issue(0, 1'b0, 3'b001, 32'h1000_0008, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("lh_access", facc, MEM_ACCESS_HALF); check("lh_rdata", rd, 32'hFFFF_8001);
        issue(0, 1'b0, 3'b101, 32'h1000_0008, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("lhu_rdata", rd, 32'h0000_8001);

        // 3: misaligned split SW / LW, 2 wait cycles per beat
        wait_cfg = 2;
        w0 = wr_total;
        issue(0, 1'b1, 3'b010, 32'h1000_0001, 32'h1122_3344);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("split_sw_cyc", cyc, 13); check("split_sw_flags", fl, 0);
        check("split_sw_nwr", wr_total - w0, 4);
        check("split_wr0_addr", wlog_addr[(w0 + 0) % 64], 32'h1000_0001);
        check("split_wr0_data", wlog_data[(w0 + 0) % 64], 32'h44);
        check("split_wr1_addr", wlog_addr[(w0 + 1) % 64], 32'h1000_0002);
        check("split_wr1_data", wlog_data[(w0 + 1) % 64], 32'h33);
        check("split_wr2_addr", wlog_addr[(w0 + 2) % 64], 32'h1000_0003);
        check("split_wr2_data", wlog_data[(w0 + 2) % 64], 32'h22);
        check("split_wr3_addr", wlog_addr[(w0 + 3) % 64], 32'h1000_0004);
        check("split_wr3_data", wlog_data[(w0 + 3) % 64], 32'h11);
        issue(0, 1'b0, 3'b010, 32'h1000_0001, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("split_lw_cyc", cyc, 13); check("split_lw_rdata", rd, 32'h1122_3344);
        wait_cfg = 0;

        // 4: rejection paths
        r0 = req1_total;
        issue(1, 1'b0, 3'b001, 32'h1000_0001, 32'h0);
        wait_resp(1, cyc, freq, facc, rd, fl);
        check("mis_cyc", cyc, 1); check("mis_flags", fl, 3'b100); check("mis_rdata", rd, 0);
        issue(1, 1'b0, 3'b011, 32'h1000_0000, 32'h0);
        wait_resp(1, cyc, freq, facc, rd, fl);
        check("ill_cyc", cyc, 1); check("ill_flags", fl, 3'b010);
        check("rej_no_mem_req", req1_total - r0, 0);
        r0 = req_total;
        issue(0, 1'b1, 3'b100, 32'h1000_0000, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("ill_store_flags", fl, 3'b010); check("ill_store_noreq", req_total - r0, 0);

        // 5: timeout and mid-split exception
        never_ready = 1'b1;
        r0 = req_total;
        issue(0, 1'b0, 3'b010, 32'h1000_0004, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("to_req_cycles", req_total - r0, 15); check("to_cyc", cyc, 16);
        check("to_flags", fl, 3'b001); check("to_rdata", rd, 0);
        never_ready = 1'b0;
        b0 = beats_total; beats_base = beats_total; exc_beat = 1;
        issue(0, 1'b0, 3'b010, 32'h1000_0011, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("exc_beats", beats_total - b0, 2); check("exc_cyc", cyc, 3);
        check("exc_flags", fl, 3'b001); check("exc_rdata", rd, 0);
        exc_beat = -1;

        // 6: async reset mid-split, then recovery
        wait_cfg = 2;
        issue(0, 1'b1, 3'b010, 32'h1000_0021, 32'hCAFE_F00D);
        repeat (4) @(negedge clk);
        check("pre_rst_mem_req", m0.mem_req, 1);
        #1 rst = 1'b0;
        #1 check("async_rst_mem_req", m0.mem_req, 0);
        check("async_rst_wr_ena", m0.mem_wr_ena, 0);
        #1 rst = 1'b1;
        wait_cfg = 0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready0, 1);
        issue(0, 1'b1, 3'b010, 32'h1000_0040, 32'h0BAD_C0DE);
        wait_resp(0, cyc, freq, facc, rd, fl);
        issue(0, 1'b0, 3'b010, 32'h1000_0040, 32'h0);
        wait_resp(0, cyc, freq, facc, rd, fl);
        check("post_rst_lw_cyc", cyc, 2); check("post_rst_lw_rdata", rd, 32'h0BAD_C0DE);

        // ena=0 blocks acceptance
        @(negedge clk);
        ena = 1'b0;
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000_0040;
        req_valid0 = 1'b1;
        r0 = req_total; seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid0;
        end
        check("ena0_req_ready", req_ready0, 0);
        check("ena0_no_req", req_total - r0, 0);
        check("ena0_no_resp", seen, 0);
        req_valid0 = 1'b0;
        ena = 1'b1;
        @(negedge clk);
        check("ena1_req_ready", req_ready0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
